// File: rtl/psi_result_streamer.sv
// Streams the indices of all set bits of a latched intersection bitmask, lowest first,
// scanning C bits per cycle and reporting the number of indices accepted.
module psi_result_streamer #(
    parameter int W  = 10000,
    parameter int C  = 32,
    parameter int IW = (W > 1) ? $clog2(W) : 1,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_mask,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_index,
    output logic          done,
    output logic [CW-1:0] count
);

    localparam int NSEG = (W + C - 1) / C;
    localparam int SW   = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int OW   = (C > 1) ? $clog2(C) : 1;
    localparam int PW   = NSEG * C;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  mask_q, mask_d;
    logic [SW-1:0] seg_q, seg_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [IW-1:0] out_index_q, out_index_d;
    logic          done_q, done_d;
    logic          in_ready_q, in_ready_d;

    // Zero-padding the mask to a whole number of segments makes bits >= W read as 0.
    logic [PW-1:0] mask_pad;
    logic [C-1:0]  seg_view [NSEG];
    logic [C-1:0]  seg_bits;
    logic          seg_hit;
    logic [OW-1:0] seg_off;

    assign mask_pad = PW'(mask_q);

    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
            assign seg_view[gi] = mask_pad[gi*C +: C];
        end
    endgenerate

    assign seg_bits = seg_view[seg_q];

    // Descending walk so the lowest set offset wins.
    always_comb begin
        seg_hit = 1'b0;
        seg_off = '0;
        for (int i = C - 1; i >= 0; i--) begin
            if (seg_bits[i]) begin
                seg_hit = 1'b1;
                seg_off = OW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        seg_d       = seg_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mask_d  = in_mask;
                    seg_d   = '0;
                    count_d = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (seg_hit) begin
                    out_index_d = IW'(int'(seg_q) * C + int'(seg_off));
                    out_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else if (seg_q == SW'(NSEG - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    seg_d = seg_q + SW'(1);
                end
            end
            S_EMIT: begin
                // Clearing the emitted bit lets the same segment be rescanned for the next one.
                if (out_ready) begin
                    mask_d[out_index_q] = 1'b0;
                    count_d             = count_q + CW'(1);
                    out_valid_d         = 1'b0;
                    state_d             = S_SCAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            seg_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            seg_q       <= seg_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule

// File: tb/tb_psi_result_streamer.sv
// Directed bench for psi_result_streamer: a W=16/C=4 instance for the main scenarios
// and a W=10/C=4 instance for the partial last segment.
module tb_psi_result_streamer;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_pass   = 0;

    // W=16, C=4 instance
    logic        in_valid, in_ready, out_valid, out_ready, done;
    logic [15:0] in_mask;
    logic [3:0]  out_index;
    logic [4:0]  count;

    // W=10, C=4 instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_done;
    logic [9:0]  b_in_mask;
    logic [3:0]  b_out_index;
    logic [3:0]  b_count;

    always #5 clk = ~clk;

    psi_result_streamer #(.W(16), .C(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .done(done), .count(count)
    );

    psi_result_streamer #(.W(10), .C(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mask(b_in_mask),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_index(b_out_index),
        .done(b_done), .count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Waits for in_ready, presents the mask for one edge; returns in cycle t+1.
    task automatic send_a(input logic [15:0] m);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        chk("send_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_mask  = m;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Accepts every index until done; rem holds the bits not yet emitted.
    task automatic stream_a(input string tag, input logic [15:0] m, input bit pulse_in);
        logic [15:0] rem;
        int          exp_idx, last_cyc, last_idx;
        bit          got_done;
        rem      = m;
        last_cyc = -1;
        last_idx = -1;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = pulse_in && (cyc % 3 == 0);
            in_mask   = 16'h0001;
            if (out_valid) begin
                exp_idx = lowest(rem);
                chk({tag, "_idx"}, 32'(out_index), exp_idx);
                $display("%s: index %0d accepted at cycle %0d", tag, out_index, cyc);
                if (exp_idx >= 0) rem[exp_idx] = 1'b0;
                if (last_cyc >= 0 && last_idx / 4 == exp_idx / 4)
                    chk({tag, "_gap"}, cyc - last_cyc, 2);
                last_cyc = cyc;
                last_idx = exp_idx;
            end
            if (done) got_done = 1'b1;
        end
        in_valid = 1'b0;
        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_all_emitted"}, rem, 0);
    endtask

    initial begin
        logic [3:0] b_exp [2];
        int         b_k;
        bit         found;

        rst = 1'b1;
        in_valid = 1'b0; in_mask = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_mask = '0; b_out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        @(negedge clk);

        // 16'h8421: indices 0,5,10,15
        send_a(16'h8421);
        stream_a("m8421", 16'h8421, 1'b0);
        chk("m8421_count", count, 4);
        $display("m8421: count %0d", count);

        // Empty mask: done exactly at t+5, in_ready back at t+6
        @(negedge clk);
        out_ready = 1'b1;
        send_a(16'h0000);
        for (int c = 1; c <= 4; c++) begin
            chk("empty_done_early", done, 0);
            chk("empty_out_valid", out_valid, 0);
            @(negedge clk);
        end
        chk("empty_done_t5", done, 1);
        chk("empty_count", count, 0);
        chk("empty_in_ready_t5", in_ready, 0);
        @(negedge clk);
        chk("empty_in_ready_t6", in_ready, 1);
        chk("empty_done_t6", done, 0);
        $display("empty: done pulse and count %0d", count);

        // 16'h0030 with back-pressure: index 4 held 5 cycles
        out_ready = 1'b0;
        send_a(16'h0030);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("bp_out_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_idx", out_index, 4);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_count", count, 0);
            @(negedge clk);
        end
        stream_a("m0030", 16'h0030, 1'b0);
        chk("m0030_count", count, 2);
        $display("m0030: count %0d", count);

        // 16'hFFFF with in_valid pulses that must be ignored
        @(negedge clk);
        send_a(16'hFFFF);
        stream_a("mFFFF", 16'hFFFF, 1'b1);
        chk("mFFFF_count", count, 16);
        @(negedge clk);
        chk("mFFFF_idle", in_ready, 1);
        chk("mFFFF_no_restart", out_valid, 0);
        $display("mFFFF: count %0d", count);

        // 16'h00F0 with reset after index 5 is accepted
        send_a(16'h00F0);
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_index == 4'd5) found = 1'b1;
        end
        chk("rstmid_found5", found, 1);
        @(negedge clk);
        chk("rstmid_pre_count", count, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_count", count, 0);
        chk("rstmid_in_ready", in_ready, 1);
        rst = 1'b0;
        $display("rstmid: reset applied mid-stream");
        send_a(16'h0001);
        stream_a("m0001", 16'h0001, 1'b0);
        chk("m0001_count", count, 1);
        $display("m0001: count %0d", count);

        // W=10, C=4: partial last segment
        b_exp[0] = 4'd0;
        b_exp[1] = 4'd9;
        b_k = 0;
        for (int i = 0; i < 50 && !b_in_ready; i++) @(negedge clk);
        chk("b_in_ready", b_in_ready, 1);
        b_in_valid  = 1'b1;
        b_in_mask   = 10'b10_0000_0001;
        b_out_ready = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            @(negedge clk);
            if (b_out_valid) begin
                chk("b_lt_w", 32'(b_out_index < 4'd10), 1);
                if (b_k < 2) chk("b_idx", b_out_index, b_exp[b_k]);
                else chk("b_extra_idx", 1, 0);
                $display("w10: index %0d accepted", b_out_index);
                b_k++;
            end
            if (b_done) found = 1'b1;
        end
        chk("b_done_seen", found, 1);
        chk("b_num_idx", b_k, 2);
        chk("b_count", b_count, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
